// File: rtl/bus_arbiter_2m_if.sv
// ----------------------------------------------------------------------------
// bus_arbiter_2m_if
// Request/grant bundle between the two bus masters and the arbiter.
//   m0_req, m1_req     : level requests from master 0 / master 1
//   m0_grant, m1_grant : registered one-hot bus ownership
//   m_sel              : master mux select (0 = master 0, 1 = master 1)
//   busy               : high whenever either grant is high
//   tenure             : cycles the current owner has held the grant, 0-based
// Modports:
//   master : the requesting side (drives requests, observes grants)
//   slave  : the arbiter itself (observes requests, drives grants)
// ----------------------------------------------------------------------------
interface bus_arbiter_2m_if #(
  parameter int CNT_W = 8
);
  logic             m0_req;
  logic             m1_req;
  logic             m0_grant;
  logic             m1_grant;
  logic             m_sel;
  logic             busy;
  logic [CNT_W-1:0] tenure;

  modport master (
    output m0_req, m1_req,
    input  m0_grant, m1_grant, m_sel, busy, tenure
  );

  modport slave (
    input  m0_req, m1_req,
    output m0_grant, m1_grant, m_sel, busy, tenure
  );
endinterface

// File: rtl/bus_arbiter_2m.sv
// ----------------------------------------------------------------------------
// bus_arbiter_2m
// Two-master round-robin bus arbiter with bounded tenure. Ties from IDLE go to
// the master that did not own the bus last; an owner that keeps requesting
// while the other master waits is preempted after MAX_HOLD granted cycles.
// Ports:
//   clk   : system clock, rising-edge active
//   reset : asynchronous, active-high reset
//   bus   : request/grant bundle (slave modport of bus_arbiter_2m_if)
// Parameters:
//   MAX_HOLD : max consecutive granted cycles while the other master waits
//              (1..255)
//   CNT_W    : tenure counter width, 2**CNT_W must exceed MAX_HOLD
// ----------------------------------------------------------------------------
module bus_arbiter_2m #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  bus_arbiter_2m_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  // Last tenure value before a waiting master takes over.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           r_state;
  logic             r_last_owner;
  logic             r_m_sel;
  logic [CNT_W-1:0] r_tenure;

  state_t           w_next_state;
  logic             w_next_last_owner;
  logic             w_next_m_sel;
  logic [CNT_W-1:0] w_next_tenure;
  logic             w_hold_done;

  assign w_hold_done = (r_tenure == HOLD_LAST);

  // Next-state and next-register values.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; an unassigned path in always_comb would infer a latch.
  always_comb begin
    w_next_state      = r_state;
    w_next_last_owner = r_last_owner;
    w_next_m_sel      = r_m_sel;
    w_next_tenure     = '0;

    unique case (r_state)
      IDLE: begin
        if (bus.m0_req && bus.m1_req) begin
          // Tie: the master that did not own the bus last wins.
          w_next_state = r_last_owner ? GNT0 : GNT1;
        end else if (bus.m0_req) begin
          w_next_state = GNT0;
        end else if (bus.m1_req) begin
          w_next_state = GNT1;
        end
      end
      GNT0: begin
        if (!bus.m0_req) begin
          w_next_state = bus.m1_req ? GNT1 : IDLE;
        end else if (bus.m1_req && w_hold_done) begin
          w_next_state = GNT1;
        end
      end
      GNT1: begin
        if (!bus.m1_req) begin
          w_next_state = bus.m0_req ? GNT0 : IDLE;
        end else if (bus.m0_req && w_hold_done) begin
          w_next_state = GNT0;
        end
      end
      default: w_next_state = IDLE;
    endcase

    // Entering a grant state (including a direct handover) records the new
    // owner and parks the mux on it; IDLE keeps both unchanged.
    if (w_next_state == GNT0) begin
      w_next_last_owner = 1'b0;
      w_next_m_sel      = 1'b0;
    end else if (w_next_state == GNT1) begin
      w_next_last_owner = 1'b1;
      w_next_m_sel      = 1'b1;
    end

    // Tenure counts only while the same owner stays granted, saturating at
    // the preemption point; any entry or IDLE leaves it at zero.
    if (w_next_state != IDLE && w_next_state == r_state) begin
      w_next_tenure = w_hold_done ? r_tenure : r_tenure + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order. All of them are
  // plain control flops, so each gets an asynchronous reset value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_owner <= 1'b1;
      r_m_sel      <= 1'b0;
      r_tenure     <= '0;
    end else begin
      r_state      <= w_next_state;
      r_last_owner <= w_next_last_owner;
      r_m_sel      <= w_next_m_sel;
      r_tenure     <= w_next_tenure;
    end
  end

  // Grants decode straight from the state register, so they are glitch-free
  // and mutually exclusive by construction.
  assign bus.m0_grant = (r_state == GNT0);
  assign bus.m1_grant = (r_state == GNT1);
  assign bus.busy     = (r_state != IDLE);
  assign bus.m_sel    = r_m_sel;
  assign bus.tenure   = r_tenure;

endmodule

// File: tb/tb_bus_arbiter_2m.sv
// ----------------------------------------------------------------------------
// tb_bus_arbiter_2m
// Drives two arbiters (MAX_HOLD=8 and MAX_HOLD=1) from the same requests and
// reset. A reference model computes each expected cycle from the ownership
// rules and pushes it into a per-arbiter queue; a monitor pops and compares
// on every falling edge.
// ----------------------------------------------------------------------------
module tb_bus_arbiter_2m;

  localparam int CNT_W = 8;

  typedef struct {
    bit g0;
    bit g1;
    bit sel;
    bit busy;
    int ten;
  } exp_t;

  logic clk;
  logic reset;
  logic m0_req;
  logic m1_req;

  int checks = 0;
  int errors = 0;

  bus_arbiter_2m_if #(.CNT_W(CNT_W)) bus8 ();
  bus_arbiter_2m_if #(.CNT_W(CNT_W)) bus1 ();

  assign bus8.m0_req = m0_req;
  assign bus8.m1_req = m1_req;
  assign bus1.m0_req = m0_req;
  assign bus1.m1_req = m1_req;

  bus_arbiter_2m #(.MAX_HOLD(8), .CNT_W(CNT_W)) u_arb8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  bus_arbiter_2m #(.MAX_HOLD(1), .CNT_W(CNT_W)) u_arb1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // owner: -1 = nobody, else master index; held = cycles of current tenure.
  int owner [2];
  int held  [2];
  int last  [2];
  bit psel  [2];
  int max_hold [2] = '{8, 1};
  exp_t q8[$];
  exp_t q1[$];

  function automatic void model_reset(int k);
    owner[k] = -1;
    held[k]  = 0;
    last[k]  = 1;
    psel[k]  = 1'b0;
  endfunction

  function automatic void give(int k, int w);
    owner[k] = w;
    held[k]  = 0;
    last[k]  = w;
    psel[k]  = w[0];
  endfunction

  function automatic void model_step(int k, bit r0, bit r1);
    bit req [2];
    int x;
    req[0] = r0;
    req[1] = r1;
    if (owner[k] < 0) begin
      if (r0 && r1) give(k, 1 - last[k]);
      else if (r0)  give(k, 0);
      else if (r1)  give(k, 1);
    end else begin
      x = owner[k];
      if (!req[x]) begin
        if (req[1-x]) give(k, 1 - x);
        else begin
          owner[k] = -1;
          held[k]  = 0;
        end
      end else if (req[1-x] && held[k] == max_hold[k] - 1) begin
        give(k, 1 - x);
      end else if (held[k] < max_hold[k] - 1) begin
        held[k]++;
      end
    end
  endfunction

  function automatic exp_t model_out(int k);
    exp_t e;
    e.g0   = (owner[k] == 0);
    e.g1   = (owner[k] == 1);
    e.sel  = psel[k];
    e.busy = (owner[k] >= 0);
    e.ten  = held[k];
    return e;
  endfunction

  initial begin
    model_reset(0);
    model_reset(1);
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        if (reset) model_reset(k);
        else       model_step(k, m0_req, m1_req);
      end
      q8.push_back(model_out(0));
      q1.push_back(model_out(1));
    end
  end

  // ---------------- monitor ----------------
  task automatic compare(input string tag, input exp_t e, input logic g0, input logic g1,
                         input logic sel, input logic bsy, input logic [CNT_W-1:0] ten);
    exp_t x;
    x = e;
    if (reset) begin
      x.g0 = 0; x.g1 = 0; x.sel = 0; x.busy = 0; x.ten = 0;
    end
    check({tag, " m0_grant"}, 32'(g0), 32'(x.g0));
    check({tag, " m1_grant"}, 32'(g1), 32'(x.g1));
    check({tag, " m_sel"},    32'(sel), 32'(x.sel));
    check({tag, " busy"},     32'(bsy), 32'(x.busy));
    check({tag, " tenure"},   32'(ten), 32'(x.ten));
    check({tag, " grant_onehot"}, 32'(g0 & g1), 32'd0);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q8.size() > 0) begin
        e = q8.pop_front();
        compare("hold8", e, bus8.m0_grant, bus8.m1_grant, bus8.m_sel, bus8.busy, bus8.tenure);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        compare("hold1", e, bus1.m0_grant, bus1.m1_grant, bus1.m_sel, bus1.busy, bus1.tenure);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic r0, input logic r1);
    m0_req = r0;
    m1_req = r1;
  endtask

  initial begin
    reset  = 1'b1;
    m0_req = 1'b0;
    m1_req = 1'b0;
    wait_cyc(2);
    reset = 1'b0;

    // Single master request, then release back to IDLE.
    set_req(1, 0); wait_cyc(4);
    set_req(0, 0); wait_cyc(3);

    // Tie right after reset, both held: alternating bounded tenures.
    reset = 1'b1; wait_cyc(1);
    reset = 1'b0; set_req(1, 1); wait_cyc(20);

    // Direct handover from GNT1 to master 0 with no IDLE gap.
    set_req(0, 1); wait_cyc(3);
    set_req(1, 0); wait_cyc(3);
    set_req(0, 0); wait_cyc(2);

    // Lone owner saturates tenure, then the other master arrives.
    set_req(0, 1); wait_cyc(20);
    set_req(1, 1); wait_cyc(3);
    set_req(0, 0); wait_cyc(2);

    // Asynchronous reset between edges during GNT1.
    set_req(0, 1); wait_cyc(3);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset m1_grant", 32'(bus8.m1_grant), 32'd0);
    check("async_reset busy",     32'(bus8.busy),     32'd0);
    check("async_reset m_sel",    32'(bus8.m_sel),    32'd0);
    wait_cyc(1);
    reset = 1'b0; set_req(1, 1); wait_cyc(4);

    // Randomized level requests with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if (m0_req) m0_req = ($urandom_range(7) != 0);
      else        m0_req = ($urandom_range(3) == 0);
      if (m1_req) m1_req = ($urandom_range(7) != 0);
      else        m1_req = ($urandom_range(3) == 0);
      reset = ($urandom_range(299) == 0);
      wait_cyc(1);
    end
    reset = 1'b0;
    set_req(0, 0);
    wait_cyc(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends on its own.
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout got %0d expected %0d", 1, 0);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bus_arbiter_2m.md
Name: bus_arbiter_2m

Overview:
Two-master bus arbiter for the shared 8-bit-address / 32-bit-data bus. It grants bus ownership to master 0 or master 1 and drives the master-side mux select that steers the winner's address and write data onto the bus. The slave-side address decoder then decodes that address. Arbitration is round-robin on ties, with a bounded tenure so that neither master can starve the other.

Parameters:
MAX_HOLD, 8, max consecutive granted cycles while the other master is waiting; legal range 1..255
CNT_W, 8, width of tenure counter; must satisfy 2**CNT_W > MAX_HOLD

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-high reset
m0_req  input  1  master 0 bus request, level; held high for the whole transfer
m1_req  input  1  master 1 bus request, level; held high for the whole transfer
m0_grant  output  1  master 0 owns the bus (registered)
m1_grant  output  1  master 1 owns the bus (registered)
m_sel  output  1  master mux select: 0 = master 0 signals, 1 = master 1 signals (registered)
busy  output  1  high whenever either grant is high
tenure  output  CNT_W  cycles the current owner has held the grant, 0-based

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. While reset is high, immediately force: state IDLE, m0_grant=0, m1_grant=0, m_sel=0, busy=0, tenure=0, last_owner=1 (so master 0 wins the first tie).
- States: IDLE, GNT0, GNT1. Encode as a 2-bit register. Grants are decoded from the state register, never combinational from the request inputs. m0_grant and m1_grant are never high together.
- Latency: a request sampled at edge N produces a grant visible after edge N (1 cycle). A request that is already high in IDLE is never delayed more than 1 cycle.
- IDLE transitions:
  - Only m0_req high -> GNT0.
  - Only m1_req high -> GNT1.
  - Both high -> grant the master != last_owner.
  - Neither high -> stay in IDLE.
- GNTx (owner x, other y), evaluated in priority order:
  1. mx_req low: if my_req is high, go to GNTy (direct handover, no gap); otherwise go to IDLE.
  2. mx_req high, my_req high, and tenure == MAX_HOLD-1: preempt, go to GNTy.
  3. Otherwise stay in GNTx.
- Preemption: the arbiter does not wait for the owner. The owner must sample its grant low and abandon or retry its transfer.
- Tenure counter:
  - Cleared to 0 on every entry to GNT0 or GNT1, including a direct handover.
  - Increments each cycle the state remains GNTx.
  - Saturates at MAX_HOLD-1 while the other master is idle.
  - Held at 0 in IDLE.
  - MAX_HOLD=1: a waiting master gets the bus after every single cycle of tenure.
- last_owner: updated to x on entry to GNTx; retained through IDLE.
- m_sel: 0 in GNT0, 1 in GNT1. In IDLE it holds its last value (bus parked on the previous owner, no glitch on the mux).
- busy = (state != IDLE).
- Request withdrawn in IDLE before it is granted: no grant is issued.
- Reset asserted mid-grant: the grant drops asynchronously. After release, arbitration restarts from IDLE with last_owner=1.

Test Plan:
1. Reset then m0_req=1 at cycle 2 -> m0_grant=1, m_sel=0, busy=1 from cycle 3; drop m0_req at cycle 6 -> IDLE at cycle 7, m_sel stays 0, tenure=0.
2. From IDLE, m0_req=m1_req=1 on the same edge right after reset -> GNT0 first. Both held, MAX_HOLD=8 -> m0_grant high for exactly 8 cycles (tenure 0..7), then m1_grant=1, m_sel=1, tenure=0. After 8 more cycles the grant returns to master 0.
3. GNT1 with m1_req falling on the same edge that m0_req is high -> m0_grant=1 on the next cycle with no IDLE gap. Grants are never both high, checked every cycle.
4. m1 alone holds the bus for 20 cycles -> tenure saturates at 7, no preemption. Raise m0_req at cycle 20 -> m0_grant=1 at cycle 21.
5. Assert reset asynchronously between edges during GNT1 -> m1_grant, busy and m_sel fall to 0 before the next edge. After release with both requesting -> GNT0.
6. MAX_HOLD=1, both requesting continuously -> grants alternate every cycle: 0,1,0,1,...; tenure is always 0.
